instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Program sequencer directly upstream of simple_cpu. Holds a small program RAM loaded
//  through a write port, keeps the PC, and issues 20b instructions to the CPU over a
//  valid/ready handshake.
//  Control-class instructions (JUMP, HALT, NOP) are executed locally and never issued.
//  Replaces bench-driven instruction stimulus with a self-running program.
// PARAMETERS
//  INSTR_WIDTH  20  instruction width; format [19:18] class, [17:16] X1, [15:14] X2,
//                   [13:12] X3, [11:4] imm8, [3:0] funct
//  PC_BITS      5   PC / program-RAM address width (depth = 2**PC_BITS = 32)
// PORTS
//  clk          in   1            clock, rising edge
//  rst          in   1            asynchronous active-low reset (asserted when 0)
//  start        in   1            1-cycle pulse; begins execution at PC 0 (from IDLE or HALTED)
//  prog_we      in   1            program-RAM write enable
//  prog_addr    in   PC_BITS      program-RAM write address
//  prog_data    in   INSTR_WIDTH  program-RAM write data
//  instruction  out  INSTR_WIDTH  instruction to simple_cpu
//  instr_valid  out  1            instruction holds a valid instruction
//  instr_ready  in   1            CPU accepts the instruction (1 cycle, when its previous instruction has completed)
//  pc           out  PC_BITS      address of the instruction being fetched/issued
//  busy         out  1            high in FETCH/DECODE/ISSUE
//  halted       out  1            high in HALTED
// BEHAVIOUR
//  - Reset: instruction=0, instr_valid=0, pc=0, busy=0, halted=0, state=IDLE.
//    RAM contents are not cleared.
//  - FSM states: IDLE, FETCH, DECODE, ISSUE, HALTED.
//    - IDLE   : start -> FETCH with pc=0.
//    - FETCH  : synchronous RAM read of mem[pc] into instr_reg -> DECODE.
//    - DECODE : class!=2'b00 -> ISSUE.
//               Class 00, funct 0000 NOP: pc+1 -> FETCH.
//               Class 00, funct 0001 JUMP: pc<=imm8[PC_BITS-1:0] -> FETCH.
//               Class 00, funct 0010 HALT -> HALTED (pc unchanged).
//               Any other class-00 funct is treated as NOP.
//    - ISSUE  : instr_valid=1, instruction=instr_reg. Transfer on valid&&ready;
//               then pc<=pc+1, valid drops next cycle -> FETCH.
//    - HALTED : start -> FETCH with pc=0.
//  - Handshake rules:
//    - instruction is stable while valid&&!ready.
//    - valid never drops without a transfer, except on reset.
//    - ready while !valid is ignored.
//  - Latency: start -> first valid = 3 cycles (FETCH, DECODE, ISSUE).
//    Back-to-back issue interval = 3 cycles + CPU stall cycles.
//  - Wrap-around: pc+1 from 2**PC_BITS-1 wraps to 0 with no flag.
//  - prog_we is honoured only in IDLE/HALTED; it is ignored in other states.
//    prog_we and start in the same cycle: the write commits and FETCH reads the new data.
//  - start while busy is ignored.
//  - Reset mid-issue: valid drops immediately (async); the CPU must tolerate an abandoned offer.
// CONFIGURATION
//  - IFU_PERF_EN defined: adds outputs perf_issued[15:0] and perf_stall[15:0].
//    - perf_issued counts transfers.
//    - perf_stall counts cycles with valid&&!ready.
//    - Both saturate at 16'hFFFF, clear on reset and on start.
//  - IFU_PERF_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  - Shared package/header (cpu_defs): INSTR_WIDTH, CLASS_CTRL=2'b00, CLASS_ALU=2'b01,
//    CLASS_LOAD_R=2'b10, CLASS_STORE_R=2'b11, FN_NOP/FN_JUMP/FN_HALT, and field-slice
//    localparams. simple_cpu uses the same package.
//  - Sub-module: ifu_prog_ram (1 write / 1 sync read, 2**PC_BITS x INSTR_WIDTH).
//    The FSM and PC live in the top level.
// TESTING
//  1. Reset with RAM preloaded: all outputs 0, state IDLE; start ignored for prog writes
//     -> no instr_valid until start.
//  2. Load 0:20'b01000111000000000000, 1:20'b01010011000000000000,
//     2:20'b00000000000000000010 (HALT); start; ready held 1
//     -> two issues in order with pc=0,1, 3 cycles apart; then halted=1 with pc=2.
//  3. Same program, ready low for 5 cycles on the first offer
//     -> instruction held stable, valid held; perf_stall=5 and perf_issued=2 with IFU_PERF_EN.
//  4. JUMP: 0:ADD, 1:20'b00000000000011110001 (JUMP 15), 15:HALT
//     -> issues pc 0 only, then halted with pc=15; JUMP never seen by CPU.
//  5. Wrap: NOP at 31, ADD at 0, 1:HALT; start with a JUMP at 0 to 31 pre-placed,
//     then rewrite 0 -> pc goes 31->0, ADD issued.
//  6. Assert rst during ISSUE with valid=1 -> valid/pc/busy 0 asynchronously.
//     Restart reproduces identical issue sequence (RAM retained).

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Definitions shared by the fetch unit and simple_cpu: instruction geometry, class/funct codes, sequencer states.
package cpu_defs_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int PC_BITS     = 5;

  localparam logic [1:0] CLASS_CTRL    = 2'b00;
  localparam logic [1:0] CLASS_ALU     = 2'b01;
  localparam logic [1:0] CLASS_LOAD_R  = 2'b10;
  localparam logic [1:0] CLASS_STORE_R = 2'b11;

  localparam logic [3:0] FN_NOP  = 4'h0;
  localparam logic [3:0] FN_JUMP = 4'h1;
  localparam logic [3:0] FN_HALT = 4'h2;

  // Instruction field boundaries: [19:18] class, X1/X2/X3 register selects, imm8, funct.
  localparam int CLASS_MSB = 19;
  localparam int CLASS_LSB = 18;
  localparam int X1_MSB    = 17;
  localparam int X1_LSB    = 16;
  localparam int X2_MSB    = 15;
  localparam int X2_LSB    = 14;
  localparam int X3_MSB    = 13;
  localparam int X3_LSB    = 12;
  localparam int IMM_MSB   = 11;
  localparam int IMM_LSB   = 4;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_HALTED
  } ifu_state_t;

endpackage

// File: rtl/ifu_prog_ram.sv
// Program RAM: one write port, one registered read port.
// Latency: read data valid the cycle after re. Backpressure: none; the sequencer never reads and writes together.
module ifu_prog_ram
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W = INSTR_WIDTH,
  parameter int ADDR_W = PC_BITS
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // rdata holds between reads, so it doubles as the instruction register.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program sequencer for simple_cpu: runs JUMP/HALT/NOP locally, issues other classes. IFU_PERF_EN adds perf_issued/perf_stall.
// Latency: start to first instr_valid 3 cycles; issue interval 3 cycles plus CPU stalls. Backpressure: offer held stable until instr_ready.
module instr_fetch_unit #(
  parameter int INSTR_WIDTH = cpu_defs_pkg::INSTR_WIDTH,
  parameter int PC_BITS     = cpu_defs_pkg::PC_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   halted
`ifdef IFU_PERF_EN
  ,
  output logic [15:0]            perf_issued,
  output logic [15:0]            perf_stall
`endif
);
  import cpu_defs_pkg::*;

  ifu_state_t             state_q, state_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_reg;
  logic                   ram_re;
  logic                   idle_like;
  logic                   start_acc;
  logic [1:0]             cls;
  logic [3:0]             funct;
  logic [7:0]             imm8;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_HALTED);
  assign start_acc = idle_like && start;

  ifu_prog_ram #(
    .DATA_W (INSTR_WIDTH),
    .ADDR_W (PC_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (prog_we && idle_like),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (ram_re),
    .raddr (pc_q),
    .rdata (instr_reg)
  );

  assign cls   = instr_reg[CLASS_MSB:CLASS_LSB];
  assign funct = instr_reg[FUNCT_MSB:FUNCT_LSB];
  assign imm8  = instr_reg[IMM_MSB:IMM_LSB];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ram_re  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        ram_re  = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (cls != CLASS_CTRL) begin
          state_d = ST_ISSUE;
        end else if (funct == FN_JUMP) begin
          pc_d    = imm8[PC_BITS-1:0];
          state_d = ST_FETCH;
        end else if (funct == FN_HALT) begin
          state_d = ST_HALTED;
        end else begin
          // Unknown control functs behave as NOP.
          pc_d    = pc_q + PC_BITS'(1);
          state_d = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          pc_d    = pc_q + PC_BITS'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_valid = (state_q == ST_ISSUE);
  assign instruction = instr_valid ? instr_reg : '0;
  assign pc          = pc_q;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_ISSUE);
  assign halted      = (state_q == ST_HALTED);

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (start_acc) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (instr_valid && instr_ready && (perf_issued != 16'hFFFF)) perf_issued <= perf_issued + 16'd1;
      if (instr_valid && !instr_ready && (perf_stall != 16'hFFFF)) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed table, hand sequences for wrap/reset, random programs against an ISA-level model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [19:0] prog_data;
  logic [19:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
`ifdef IFU_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
`ifdef IFU_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- observation of one run ----------------
  int          q_pc[$];
  logic [19:0] q_ins[$];
  int          q_cyc[$];
  int          q_trace[$];
  int          stalls, stab_err, halt_cyc, halt_pc;

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [19:0] qw(input logic [19:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 20'hFFFFF;
  endfunction

  task automatic wr(input int a, input logic [19:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 5'(a);
    prog_data = d;
  endtask

  // Pulses start (optionally with a same-cycle write) then watches the DUT each negedge.
  task automatic collect(input int stall_first, input bit rnd, input int max_xfer, input bit poke,
                         input bit sw, input logic [4:0] sa, input logic [19:0] sd);
    bit          hold;
    bit          r;
    logic [19:0] held;
    q_pc.delete(); q_ins.delete(); q_cyc.delete(); q_trace.delete();
    stalls = 0; stab_err = 0; halt_cyc = -1; halt_pc = -1; hold = 0; held = '0;
    @(negedge clk);
    start = 1'b1; prog_we = sw; prog_addr = sa; prog_data = sd; instr_ready = 1'b0;
    @(negedge clk);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      start   = 1'b0;
      prog_we = 1'b0;
      q_trace.push_back(int'(pc));
      if (hold && (!instr_valid || instruction !== held)) stab_err++;
      if (halted) begin
        halt_cyc = cyc;
        halt_pc  = int'(pc);
        break;
      end
      if (poke && cyc == 1) begin
        prog_we = 1'b1; prog_addr = 5'd1; prog_data = 20'h00002;
      end
      if (poke && cyc == 2) start = 1'b1;
      r = rnd ? 1'($urandom_range(0, 1)) : (stalls >= stall_first);
      instr_ready = r;
      if (instr_valid && !r) begin
        stalls++; hold = 1; held = instruction;
      end else begin
        hold = 0;
      end
      if (instr_valid && r) begin
        q_pc.push_back(int'(pc));
        q_ins.push_back(instruction);
        q_cyc.push_back(cyc);
        if (q_pc.size() >= max_xfer) break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- ISA-level reference model ----------------
  logic [19:0] prog [32];
  int          m_pc[$];
  logic [19:0] m_ins[$];
  int          m_halt_pc, m_ctrl;
  bit          m_ok;

  task automatic model_run();
    int          p;
    logic [19:0] w;
    m_pc.delete(); m_ins.delete();
    m_ctrl = 0; m_ok = 0; m_halt_pc = -1; p = 0;
    for (int s = 0; s < 64; s++) begin
      w = prog[p];
      if (w[19:18] != 2'b00) begin
        m_pc.push_back(p); m_ins.push_back(w); p = (p + 1) % 32;
      end else if (w[3:0] == 4'h1) begin
        p = int'(w[11:4]) % 32; m_ctrl++;
      end else if (w[3:0] == 4'h2) begin
        m_halt_pc = p; m_ok = 1; return;
      end else begin
        p = (p + 1) % 32; m_ctrl++;
      end
    end
  endtask

  task automatic gen_prog();
    logic [19:0] w;
    int          r;
    for (int i = 0; i < 32; i++) begin
      r = $urandom_range(0, 9);
      w = 20'($urandom);
      case (r)
        0, 1:    w = {2'b00, w[17:4], 4'h2};
        2, 3:    w = {2'b00, w[17:4], 4'h1};
        4:       w = {2'b00, w[17:4], 4'h0};
        5:       w = {2'b00, w[17:4], 4'($urandom_range(3, 15))};
        default: if (w[19:18] == 2'b00) w[19:18] = 2'b01;
      endcase
      prog[i] = w;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [2:0]        nw;
    logic [3:0][4:0]   a;
    logic [3:0][19:0]  d;
    logic [3:0]        stall;
    logic              poke;
    logic [1:0]        n;
    logic [4:0]        pc0, pc1;
    logic [19:0]       i0, i1;
    logic [4:0]        hpc;
    logic [7:0]        c0, gap, hcyc;
  } vec_t;

  vec_t        v [4];
  int          r1_pc[$];
  logic [19:0] r1_ins[$];
  int          r1_cyc[$];

  initial begin
    v[0] = '0; v[0].nw = 3; v[0].a[0] = 0; v[0].a[1] = 1; v[0].a[2] = 2;
    v[0].d[0] = 20'h47000; v[0].d[1] = 20'h53000; v[0].d[2] = 20'h00002; v[0].poke = 1;
    v[0].n = 2; v[0].pc0 = 0; v[0].pc1 = 1; v[0].i0 = 20'h47000; v[0].i1 = 20'h53000;
    v[0].hpc = 2; v[0].c0 = 3; v[0].gap = 3; v[0].hcyc = 9;
    v[1] = v[0]; v[1].poke = 0; v[1].stall = 5; v[1].c0 = 8; v[1].hcyc = 14;
    v[2] = '0; v[2].nw = 3; v[2].a[0] = 0; v[2].a[1] = 1; v[2].a[2] = 15;
    v[2].d[0] = 20'h47000; v[2].d[1] = 20'h000F1; v[2].d[2] = 20'h00002;
    v[2].n = 1; v[2].pc0 = 0; v[2].i0 = 20'h47000; v[2].hpc = 15; v[2].c0 = 3; v[2].hcyc = 8;
    v[3] = '0; v[3].nw = 3; v[3].a[0] = 0; v[3].a[1] = 1; v[3].a[2] = 2;
    v[3].d[0] = 20'h00000; v[3].d[1] = 20'h53000; v[3].d[2] = 20'h00002; v[3].stall = 1;
    v[3].n = 1; v[3].pc0 = 1; v[3].i0 = 20'h53000; v[3].hpc = 2; v[3].c0 = 6; v[3].hcyc = 9;

    rst = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; instr_ready = 1'b0;

    // 1. reset state; program writes alone never start execution
    #12;
    chk("rst instruction", 32'(instruction), 0);
    chk("rst valid", 32'(instr_valid), 0);
    chk("rst pc", 32'(pc), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst halted", 32'(halted), 0);
`ifdef IFU_PERF_EN
    chk("rst perf_issued", 32'(perf_issued), 0);
    chk("rst perf_stall", 32'(perf_stall), 0);
`endif
    @(negedge clk); rst = 1'b1;
    wr(0, 20'h47000); wr(1, 20'h00002);
    @(negedge clk); prog_we = 1'b0; instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle valid", 32'(instr_valid), 0);
    chk("idle busy", 32'(busy), 0);
    instr_ready = 1'b0;

    // 2-4. directed programs
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < int'(v[k].nw); j++) wr(int'(v[k].a[j]), v[k].d[j]);
      collect(int'(v[k].stall), 0, 10, v[k].poke, 0, 5'd0, 20'h0);
      chk($sformatf("v%0d count", k), 32'(q_pc.size()), 32'(v[k].n));
      chk($sformatf("v%0d pc0", k), 32'(qi(q_pc, 0)), 32'(v[k].pc0));
      chk($sformatf("v%0d ins0", k), 32'(qw(q_ins, 0)), 32'(v[k].i0));
      chk($sformatf("v%0d first cyc", k), 32'(qi(q_cyc, 0)), 32'(v[k].c0));
      if (v[k].n == 2) begin
        chk($sformatf("v%0d pc1", k), 32'(qi(q_pc, 1)), 32'(v[k].pc1));
        chk($sformatf("v%0d ins1", k), 32'(qw(q_ins, 1)), 32'(v[k].i1));
        chk($sformatf("v%0d gap", k), 32'(qi(q_cyc, 1) - qi(q_cyc, 0)), 32'(v[k].gap));
      end
      chk($sformatf("v%0d halt pc", k), 32'(halt_pc), 32'(v[k].hpc));
      chk($sformatf("v%0d halt cyc", k), 32'(halt_cyc), 32'(v[k].hcyc));
      chk($sformatf("v%0d stalls", k), 32'(stalls), 32'(v[k].stall));
      chk($sformatf("v%0d stable", k), 32'(stab_err), 0);
`ifdef IFU_PERF_EN
      chk($sformatf("v%0d perf_issued", k), 32'(perf_issued), 32'(v[k].n));
      chk($sformatf("v%0d perf_stall", k), 32'(perf_stall), 32'(v[k].stall));
`endif
    end

    // 5. wrap: 0 JUMP 30 written together with start, 30 ADD, 31 NOP wraps to 0
    wr(0, 20'h00002); wr(30, 20'h47000); wr(31, 20'h00000);
    collect(0, 0, 2, 0, 1, 5'd0, 20'h001E1);
    chk("wrap count", 32'(q_pc.size()), 2);
    chk("wrap pc0", 32'(qi(q_pc, 0)), 30);
    chk("wrap pc1", 32'(qi(q_pc, 1)), 30);
    chk("wrap ins1", 32'(qw(q_ins, 1)), 32'h47000);
    chk("wrap cyc0", 32'(qi(q_cyc, 0)), 5);
    chk("wrap cyc1", 32'(qi(q_cyc, 1)), 12);
    chk("wrap pc at 31", 32'(qi(q_trace, 5)), 31);
    chk("wrap pc to 0", 32'(qi(q_trace, 7)), 0);
    r1_pc = q_pc; r1_ins = q_ins; r1_cyc = q_cyc;

    // 6. async reset with an offer pending, then restart from retained RAM
    @(negedge clk); instr_ready = 1'b0;
    for (int i = 0; i < 40 && !instr_valid; i++) @(negedge clk);
    chk("offer before reset", 32'(instr_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst valid", 32'(instr_valid), 0);
    chk("arst pc", 32'(pc), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst instruction", 32'(instruction), 0);
    @(negedge clk); rst = 1'b1;
    collect(0, 0, 2, 0, 0, 5'd0, 20'h0);
    chk("restart count", 32'(q_pc.size()), 32'(r1_pc.size()));
    for (int i = 0; i < r1_pc.size(); i++) begin
      chk($sformatf("restart pc%0d", i), 32'(qi(q_pc, i)), 32'(r1_pc[i]));
      chk($sformatf("restart ins%0d", i), 32'(qw(q_ins, i)), 32'(r1_ins[i]));
      chk($sformatf("restart cyc%0d", i), 32'(qi(q_cyc, i)), 32'(r1_cyc[i]));
    end
    @(negedge clk); instr_ready = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk); rst = 1'b1;

    // random programs, random CPU readiness
    for (int t = 0; t < 25; t++) begin
      int tries;
      tries = 0;
      do begin
        gen_prog();
        model_run();
        tries++;
      end while (!m_ok && tries < 50);
      if (!m_ok) begin
        prog[0] = 20'h00002;
        model_run();
      end
      for (int i = 0; i < 32; i++) wr(i, prog[i]);
      collect(0, 1, 1000, 0, 0, 5'd0, 20'h0);
      chk($sformatf("rnd%0d count", t), 32'(q_pc.size()), 32'(m_pc.size()));
      for (int i = 0; i < m_pc.size(); i++) begin
        chk($sformatf("rnd%0d pc%0d", t, i), 32'(qi(q_pc, i)), 32'(m_pc[i]));
        chk($sformatf("rnd%0d ins%0d", t, i), 32'(qw(q_ins, i)), 32'(m_ins[i]));
      end
      chk($sformatf("rnd%0d halt pc", t), 32'(halt_pc), 32'(m_halt_pc));
      chk($sformatf("rnd%0d halt cyc", t), 32'(halt_cyc),
          32'(1 + 2 * m_ctrl + 2 + 3 * m_pc.size() + stalls));
      chk($sformatf("rnd%0d stable", t), 32'(stab_err), 0);
`ifdef IFU_PERF_EN
      chk($sformatf("rnd%0d perf_issued", t), 32'(perf_issued), 32'(m_pc.size()));
      chk($sformatf("rnd%0d perf_stall", t), 32'(perf_stall), 32'(stalls));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
